mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Shares a single main-memory port between the instruction cache (read-only requester I) and the data cache (read/write requester D).
- Each requester uses the same level-held request / busy-release protocol as the caches' memory interface.
- Arbitration is round-robin, and a grant is locked for the whole transaction.
- A watchdog flags memory transactions that never complete.
- Sits between the cache pair and the main-memory model in the pipeline top level.

Parameters:
- DATA_WIDTH, 32, address and data width.
- TIMEOUT_CYCLES, 1024, maximum number of cycles mem_busy may stay high during a grant; 0 disables the watchdog.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset, sampled on the rising edge of clk.
- i_addr  in  DATA_WIDTH  requester I address.
- i_read  in  1  requester I read request, held until i_busy is seen low.
- i_read_data  out  DATA_WIDTH  read data to I.
- i_busy  out  1  I transaction not yet complete.
- d_addr  in  DATA_WIDTH  requester D address.
- d_write_data  in  DATA_WIDTH  requester D write data.
- d_read  in  1  requester D read request.
- d_write  in  1  requester D write request; d_read and d_write are never both high.
- d_read_data  out  DATA_WIDTH  read data to D.
- d_busy  out  1  D transaction not yet complete.
- mem_addr  out  DATA_WIDTH  memory address.
- mem_write_data  out  DATA_WIDTH  memory write data.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_read_data  in  DATA_WIDTH  memory read data, valid in the cycle mem_busy is low.
- mem_busy  in  1  memory working; low during a request marks completion in that cycle.
- grant_d  out  1  status: 1 = D currently owns memory.
- err_timeout  out  1  sticky watchdog flag.
- err_src  out  1  requester that timed out (0 = I, 1 = D).

Behaviour:
- **States:** IDLE, GRANT_I, GRANT_D, held in a registered FSM. Registers also hold last_grant (1 bit) and wdog (counter of width clog2(TIMEOUT_CYCLES+1)).
- **Reset:** state = IDLE, last_grant = D (so I wins the first tie), wdog = 0, err_timeout = 0, err_src = 0.
  - Outputs during reset: mem_read = mem_write = 0, i_busy = d_busy = 1, grant_d = 0.
  - A reset asserted mid-transaction drops the strobes the following cycle; the memory request is abandoned.
- **Requests:** req_I = i_read; req_D = d_read | d_write.
- **IDLE:**
  - Only one requester asserting: go to its GRANT state.
  - Both asserting: grant the requester that is not last_grant.
  - Neither asserting: stay in IDLE.
  - Arbitration latency is 1 cycle: a request seen at cycle t has the memory strobe asserted at t+1.
- **GRANT_x, memory outputs (combinational):**
  - mem_addr = x_addr.
  - mem_write_data = d_write_data.
  - mem_read/mem_write = requester x's read/write request.
  - In IDLE: strobes are 0, and mem_addr / mem_write_data carry d_addr / d_write_data.
- **Busy outputs (combinational):**
  - x_busy = 0 only when state == GRANT_x and mem_busy == 0; otherwise x_busy = 1.
  - The non-granted requester always sees busy = 1.
- **Completion:** in GRANT_x, the cycle in which mem_busy == 0.
  - last_grant is set to x.
  - Next state is GRANT of the other requester if it is requesting, otherwise IDLE. There is no dead cycle.
  - The completing requester is excluded from arbitration in the completion cycle, because its request is still high.
- **Request dropped:** if x drops its request while granted (caches never do), return to IDLE next cycle without setting last_grant.
- **Read data:** i_read_data = d_read_data = mem_read_data, passed straight through. Requesters use it only in their busy-low cycle.
- **Watchdog:**
  - wdog clears on every state change and increments each GRANT cycle with mem_busy high.
  - When wdog reaches TIMEOUT_CYCLES with mem_busy still high: set err_timeout = 1 and err_src = x, move to IDLE, and set last_grant = x.
  - The requester's busy stays high, so it re-requests and is re-arbitrated.
  - err_timeout clears only on reset.
- grant_d = (state == GRANT_D).
- **D write-miss:** a fill read followed by a write-through is two separate transactions; an I grant may interleave between them.

Decomposition:
- Shared package `mem_arb_pkg`:
  - State encoding: IDLE = 2'b00, GRANT_I = 2'b01, GRANT_D = 2'b10.
  - Requester IDs: REQ_I = 0, REQ_D = 1.
- Natural sub-module: `rr_arbiter2`, a 2-way round-robin pick from (req_I, req_D, last_grant, exclude) producing a grant ID and a valid signal. The rest stays in `mem_arbiter`.

Test Plan:
- **Reset, then single I read:** i_read=1, i_addr=0x100; memory holds busy for 3 cycles and returns 0xCAFE0001. Required: mem_read=1 and mem_addr=0x100 from cycle 1; i_busy low exactly in the completion cycle with i_read_data=0xCAFE0001; d_busy=1 throughout.
- **Simultaneous requests after reset:** i_read and d_read both high. Required: I is granted first; D is granted in the cycle after I's completion with no IDLE cycle; then, with both requesting again, D follows I and I follows D, alternating.
- **D write:** d_write=1, d_addr=0x2004, d_write_data=0x12345678, memory busy for 2 cycles. Required: mem_write=1 with those values for 3 cycles; mem_read=0; grant_d=1.
- **Watchdog:** TIMEOUT_CYCLES=8, mem_busy stuck high during a D read. Required: err_timeout=1 and err_src=1 after 8 busy cycles; FSM in IDLE; a pending I is granted next; err_timeout stays set until reset.
- **Reset mid-grant:** reset is pulsed during GRANT_D. Required: the next cycle has mem_read = mem_write = 0, both busy outputs = 1, err_timeout = 0, and the first post-reset tie goes to I.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the I/D main-memory arbiter.
//   arb_state_t : FSM state encoding (IDLE, GRANT_I, GRANT_D)
//   REQ_I/REQ_D : requester identifiers used for last_grant, exclusion and err_src
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        GRANT_I = 2'b01,
        GRANT_D = 2'b10
    } arb_state_t;

    localparam logic REQ_I = 1'b0;
    localparam logic REQ_D = 1'b1;

    // Map a requester id onto the grant state that serves it.
    function automatic arb_state_t grant_state(input logic id);
        return (id == REQ_D) ? GRANT_D : GRANT_I;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick between the instruction (I) and data (D) requesters.
// Ports:
//   i_req_i, i_req_d : raw requests
//   i_last_grant     : requester that most recently completed (loses a tie)
//   i_excl_en        : enable exclusion of one requester this cycle
//   i_excl_id        : requester to exclude (the one just completing)
//   o_grant_id       : chosen requester (REQ_I / REQ_D)
//   o_valid          : at least one eligible requester
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic i_req_i,
    input  logic i_req_d,
    input  logic i_last_grant,
    input  logic i_excl_en,
    input  logic i_excl_id,
    output logic o_grant_id,
    output logic o_valid
);

    logic w_cand_i;
    logic w_cand_d;

    assign w_cand_i = i_req_i & ~(i_excl_en & (i_excl_id == REQ_I));
    assign w_cand_d = i_req_d & ~(i_excl_en & (i_excl_id == REQ_D));
    assign o_valid  = w_cand_i | w_cand_d;

    always_comb begin
        o_grant_id = REQ_I;
        if (w_cand_i && w_cand_d) begin
            o_grant_id = ~i_last_grant;
        end else if (w_cand_d) begin
            o_grant_id = REQ_D;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one main-memory port between the instruction cache (read-only, I)
// and the data cache (read/write, D). Level-held request / busy-release
// handshake on both sides, round-robin arbitration, grant locked for the
// whole transaction, and a watchdog that abandons transactions whose
// mem_busy never drops.
// Ports:
//   clk, reset                        : clock, synchronous active-high reset
//   i_addr, i_read                    : I request
//   i_read_data, i_busy               : I response
//   d_addr, d_write_data, d_read,
//   d_write                           : D request
//   d_read_data, d_busy               : D response
//   mem_addr, mem_write_data,
//   mem_read, mem_write               : memory request
//   mem_read_data, mem_busy           : memory response
//   grant_d                           : D currently owns memory
//   err_timeout, err_src              : sticky watchdog flag and offending requester
//
// state   | meaning
// --------+--------------------------------------------------
// IDLE    | no owner; arbitrate among current requests
// GRANT_I | I owns memory until mem_busy drops
// GRANT_D | D owns memory until mem_busy drops
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] i_addr,
    input  logic                  i_read,
    output logic [DATA_WIDTH-1:0] i_read_data,
    output logic                  i_busy,
    input  logic [DATA_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_write_data,
    input  logic                  d_read,
    input  logic                  d_write,
    output logic [DATA_WIDTH-1:0] d_read_data,
    output logic                  d_busy,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    output logic                  mem_read,
    output logic                  mem_write,
    input  logic [DATA_WIDTH-1:0] mem_read_data,
    input  logic                  mem_busy,
    output logic                  grant_d,
    output logic                  err_timeout,
    output logic                  err_src
);

    // A zero timeout disables the watchdog; keep the counter at least 1 bit wide.
    localparam int                WDOG_W     = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit                WDOG_EN    = (TIMEOUT_CYCLES > 0);
    localparam logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(TIMEOUT_CYCLES);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    logic              r_last_grant;
    logic              w_last_grant_nxt;
    logic [WDOG_W-1:0] r_wdog;
    logic [WDOG_W-1:0] w_wdog_nxt;
    logic              r_err_timeout;
    logic              r_err_src;
    logic              w_err_set;

    logic w_req_i;
    logic w_req_d;
    logic w_granted;
    logic w_own_id;
    logic w_own_req;
    logic w_wdog_fire;
    logic w_pick_id;
    logic w_pick_valid;

    assign w_req_i   = i_read;
    assign w_req_d   = d_read | d_write;
    assign w_granted = (r_state == GRANT_I) || (r_state == GRANT_D);
    assign w_own_id  = (r_state == GRANT_D) ? REQ_D : REQ_I;
    assign w_own_req = (w_own_id == REQ_D) ? w_req_d : w_req_i;

    // Fires once mem_busy has already been high for TIMEOUT_CYCLES grant
    // cycles and is still high now.
    assign w_wdog_fire = WDOG_EN && w_granted && mem_busy && (r_wdog == WDOG_LIMIT);

    // While granted, the owner is excluded: in its completion cycle its
    // request is still high and must not win the hand-over.
    rr_arbiter2 u_rr_arbiter2 (
        .i_req_i      (w_req_i),
        .i_req_d      (w_req_d),
        .i_last_grant (r_last_grant),
        .i_excl_en    (w_granted),
        .i_excl_id    (w_own_id),
        .o_grant_id   (w_pick_id),
        .o_valid      (w_pick_valid)
    );

    always_comb begin
        w_state_nxt      = r_state;
        w_last_grant_nxt = r_last_grant;
        w_err_set        = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pick_valid) begin
                    w_state_nxt = grant_state(w_pick_id);
                end
            end
            GRANT_I, GRANT_D: begin
                if (!w_own_req) begin
                    // Owner withdrew: release without touching fairness history.
                    w_state_nxt = IDLE;
                end else if (!mem_busy) begin
                    w_last_grant_nxt = w_own_id;
                    w_state_nxt      = w_pick_valid ? grant_state(w_pick_id) : IDLE;
                end else if (w_wdog_fire) begin
                    w_state_nxt      = IDLE;
                    w_last_grant_nxt = w_own_id;
                    w_err_set        = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_wdog_nxt = r_wdog;
        if (w_state_nxt != r_state) begin
            w_wdog_nxt = '0;
        end else if (WDOG_EN && w_granted && mem_busy && (r_wdog != WDOG_LIMIT)) begin
            w_wdog_nxt = r_wdog + WDOG_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_last_grant  <= REQ_D;
            r_wdog        <= '0;
            r_err_timeout <= 1'b0;
            r_err_src     <= REQ_I;
        end else begin
            r_state      <= w_state_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_wdog       <= w_wdog_nxt;
            if (w_err_set) begin
                r_err_timeout <= 1'b1;
                r_err_src     <= w_own_id;
            end
        end
    end

    // Outputs are forced quiet while reset is high so a reset landing
    // mid-transaction never shows a strobe or a busy release.
    always_comb begin
        mem_addr       = d_addr;
        mem_write_data = d_write_data;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        i_busy         = 1'b1;
        d_busy         = 1'b1;
        if (!reset) begin
            case (r_state)
                GRANT_I: begin
                    mem_addr = i_addr;
                    mem_read = i_read;
                    i_busy   = mem_busy;
                end
                GRANT_D: begin
                    mem_read  = d_read;
                    mem_write = d_write;
                    d_busy    = mem_busy;
                end
                default: ;
            endcase
        end
    end

    assign i_read_data = mem_read_data;
    assign d_read_data = mem_read_data;
    assign grant_d     = (r_state == GRANT_D) && !reset;
    assign err_timeout = r_err_timeout;
    assign err_src     = r_err_src;

endmodule
